mdu: RTL
========

# mdu

Multiply/divide unit for the pipelined CPU: takes MULT/MULTU/DIV/DIVU from the execute stage, holds the HI/LO result pending for a fixed latency, then commits it to the HI/LO registers. It also services MTHI/MTLO writes. It produces the busy/stall signal the hazard logic uses to hold any MD-class instruction in decode until the unit is free.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU
- DIV_CYCLES, 10, busy cycles for DIV/DIVU
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  execute-stage MD op valid this cycle
- md_op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- rs_val  in  32  operand A / dividend
- rt_val  in  32  operand B / divisor
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  32  MTHI/MTLO data (rs value)
- md_use  in  1  decode stage holds MULT/DIV/MFHI/MFLO/MTHI/MTLO
- busy  out  1  operation in flight
- stall  out  1  md_use & (busy | start), combinational
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Registers: hi, lo, pend_hi, pend_lo, cnt (4 bits). busy = (cnt != 0).
- States: IDLE (cnt==0) and RUN (cnt!=0). Implicit in cnt, no separate state register.
- IDLE and start=1: the result is computed combinationally from rs_val/rt_val and latched into pend_hi/pend_lo. cnt loads MULT_CYCLES or DIV_CYCLES.
- RUN: cnt decrements each edge. On the edge where cnt goes 1->0, hi<=pend_hi and lo<=pend_lo.
- start while busy=1 is ignored; the hazard unit guarantees it does not occur. The bench checks that hi, lo and cnt are unaffected.
- MTHI/MTLO are accepted only when busy=0 and start=0, and write on the next edge. If start and mthi/mtlo are asserted in the same cycle, start wins and the move is dropped. While busy=1 the move is ignored.
- MULT: signed 64-bit product, {hi,lo} = rs*rt. MULTU: unsigned product.
- DIV: signed, quotient truncates toward zero; lo=quotient, hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt_val==0): the operation still runs DIV_CYCLES, busy behaves normally, and hi/lo keep their prior values at commit (pend loaded from current hi/lo).
- The hi/lo outputs always show committed values. There is no forwarding of pend.

## Timing
- Reset: hi=0, lo=0, pend_hi=0, pend_lo=0, cnt=0, busy=0. stall follows its inputs.
- Reset mid-operation aborts the op; no commit occurs.
- start sampled at edge E0: busy=1 for exactly N cycles after E0. The new hi/lo are visible in the first cycle in which busy=0.
  - MULT: visible 5 cycles after E0.
  - DIV: visible 10 cycles after E0.
- MTHI/MTLO: the value is visible in the cycle after the write edge.
- Back-to-back: start may be asserted in the first cycle busy=0. The commit of the previous op and the capture of the new op share that edge boundary without conflict, because the commit happened on the prior edge.
- stall is combinational, with no register delay.

## Structure
- Shared package `mdu_pkg`:
  - op encodings MD_MULT=2'd0, MD_MULTU=2'd1, MD_DIV=2'd2, MD_DIVU=2'd3;
  - default latency constants.
- One natural sub-module, `mdu_calc`: purely combinational. Inputs: op, a, b, current hi/lo. Outputs: 64-bit {hi,lo} result, including the divide-by-zero hold and overflow rules.
- `mdu` itself holds the counter, the pending registers and the commit logic.

## Test plan
- MULT, rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV, rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with rt=0 after MTHI 0x1234 and MTLO 0x5678 -> busy 10 cycles, then hi=0x1234 and lo=0x5678 unchanged.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - MTLO 0xAA issued during busy -> ignored.
  - md_use=1 during busy -> stall=1.
- MULT started, reset asserted at cycle 3 -> hi=lo=0 and busy=0 immediately. No commit later; a fresh MULT after reset completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and default latencies.
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result for one MD op, including divide-by-zero hold and
// the signed-divide overflow case.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [63:0] res
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;

  always_comb begin
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sq  = '0;
    sr  = '0;
    res = {hi_in, lo_in};
    unique case (md_op_e'(op))
      MD_MULT:  res = sa * sb;
      MD_MULTU: res = {32'h0, a} * {32'h0, b};
      MD_DIV: begin
        if (b != '0) begin
          // most-negative / -1 would overflow the 32-bit quotient; it wraps to itself
          if (a == 32'h8000_0000 && b == '1) begin
            res = {32'h0, 32'h8000_0000};
          end else begin
            sq  = $signed(a) / $signed(b);
            sr  = $signed(a) % $signed(b);
            res = {sr, sq};
          end
        end
      end
      MD_DIVU: begin
        if (b != '0) res = {a % b, a / b};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: captures an MD result into pending regs, counts out a
// fixed latency, then commits to architectural HI/LO. Also services MTHI/MTLO.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [63:0]      calc_res;
  logic             idle;

  mdu_calc u_calc (
    .op    (md_op),
    .a     (rs_val),
    .b     (rt_val),
    .hi_in (hi_q),
    .lo_in (lo_q),
    .res   (calc_res)
  );

  assign idle = (cnt_q == '0);

  // IDLE/RUN is implied by cnt; start while running and moves while busy are dropped
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (idle) begin
      if (start) begin
        pend_hi_d = calc_res[63:32];
        pend_lo_d = calc_res[31:0];
        cnt_d     = (md_op_e'(md_op) inside {MD_DIV, MD_DIVU}) ? CNT_W'(DIV_CYCLES)
                                                                : CNT_W'(MULT_CYCLES);
      end else begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy  = ~idle;
  assign stall = md_use & (busy | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
